// File: rtl/core_config_pkg.sv
// Core-wide widths plus the Zicsr opcode and CSR access-unit state encodings.
package core_config_pkg;

  localparam int XLEN       = 32;
  localparam int CSR_ADDR_W = 12;

  // addr[11:10] == 2'b11 marks the read-only CSR space
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  typedef enum logic [2:0] {
    CSR_ST_IDLE   = 3'd0,
    CSR_ST_READ   = 3'd1,
    CSR_ST_MODIFY = 3'd2,
    CSR_ST_WRITE  = 3'd3,
    CSR_ST_RESP   = 3'd4
  } csr_unit_state_t;

endpackage

// File: rtl/csr_alu.sv
// Combinational Zicsr modify step: old value and source operand in, new value and write intent out.
// Zero latency; no handshake of its own.
module csr_alu
  import core_config_pkg::*;
(
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  input  logic [1:0]      op,
  input  logic            rs1_nz,
  output logic [XLEN-1:0] new_val,
  output logic            do_wr
);

  always_comb begin
    new_val = old_val;
    case (op)
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  // set/clear with x0 or uimm 0 must not write, even to read-only CSRs
  assign do_wr = (op == 2'b01) | rs1_nz;

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer: request at E0, csr_we in the third cycle, response from the fourth.
// One request in flight; req_ready is low until the response handshake completes.
module csr_access_unit
  import core_config_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [4:0]            req_rs1_field,
  input  logic [XLEN-1:0]       req_rs1_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_data,
  output logic                  rsp_illegal,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_wa,
  output logic [XLEN-1:0]       csr_wd,
  output logic [CSR_ADDR_W-1:0] csr_ra,
  input  logic [XLEN-1:0]       csr_rd,
  input  logic                  csr_err
);

  localparam logic [2:0] S_IDLE   = CSR_ST_IDLE;
  localparam logic [2:0] S_READ   = CSR_ST_READ;
  localparam logic [2:0] S_MODIFY = CSR_ST_MODIFY;
  localparam logic [2:0] S_WRITE  = CSR_ST_WRITE;
  localparam logic [2:0] S_RESP   = CSR_ST_RESP;

  logic [2:0]            state;
  logic [2:0]            funct3_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [4:0]            field_q;
  logic [XLEN-1:0]       data_q;
  logic                  err_q;
  logic                  do_wr_q;
  logic                  illegal_q;
  logic [XLEN-1:0]       old_q;
  logic [XLEN-1:0]       wd_q;

  logic [XLEN-1:0]       src;
  logic [XLEN-1:0]       alu_new;
  logic                  alu_do_wr;
  logic                  illegal_c;

  assign src = funct3_q[2] ? {{(XLEN-5){1'b0}}, field_q} : data_q;

  csr_alu u_alu (
    .old_val (csr_rd),
    .src     (src),
    .op      (funct3_q[1:0]),
    .rs1_nz  (field_q != 5'd0),
    .new_val (alu_new),
    .do_wr   (alu_do_wr)
  );

  assign illegal_c = (funct3_q[1:0] == 2'b00) | err_q |
                     (alu_do_wr & (addr_q[11:10] == CSR_RO_PREFIX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      funct3_q  <= '0;
      addr_q    <= '0;
      field_q   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      do_wr_q   <= 1'b0;
      illegal_q <= 1'b0;
      old_q     <= '0;
      wd_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          funct3_q <= req_funct3;
          addr_q   <= req_addr;
          field_q  <= req_rs1_field;
          data_q   <= req_rs1_data;
          state    <= S_READ;
        end
        S_READ: begin
          err_q <= csr_err;
          state <= S_MODIFY;
        end
        S_MODIFY: begin
          // an illegal access never leaks the CSR contents to rd
          old_q     <= illegal_c ? '0 : csr_rd;
          wd_q      <= alu_new;
          do_wr_q   <= alu_do_wr;
          illegal_q <= illegal_c;
          state     <= S_WRITE;
        end
        S_WRITE: state <= S_RESP;
        S_RESP:  if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign rsp_data    = old_q;
  assign rsp_illegal = illegal_q;
  assign csr_we      = (state == S_WRITE) & do_wr_q & ~illegal_q;
  assign csr_wa      = addr_q;
  assign csr_ra      = addr_q;
  assign csr_wd      = wd_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit against a small behavioural CSR file.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [4:0]  req_rs1_field;
  logic [31:0] req_rs1_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic        csr_we;
  logic [11:0] csr_wa;
  logic [31:0] csr_wd;
  logic [11:0] csr_ra;
  logic [31:0] csr_rd;
  logic        csr_err;

  int vectors = 0;
  int miscompares = 0;
  int we_count = 0;

  logic [31:0] mem [0:4095];
  logic        mapped [0:4095];

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_field(req_rs1_field), .req_rs1_data(req_rs1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_illegal(rsp_illegal), .csr_we(csr_we), .csr_wa(csr_wa), .csr_wd(csr_wd),
    .csr_ra(csr_ra), .csr_rd(csr_rd), .csr_err(csr_err)
  );

  assign csr_err = ~mapped[csr_ra];

  // CSR file model: registered read port, full-width write, write counter
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 32'h0;
      mapped[i] = 1'b0;
    end
    mem[12'h340] = 32'h1234_5678; mapped[12'h340] = 1'b1;
    mem[12'h300] = 32'h0000_1800; mapped[12'h300] = 1'b1;
    mem[12'h304] = 32'h0000_0888; mapped[12'h304] = 1'b1;
    mem[12'h305] = 32'h0000_000F; mapped[12'h305] = 1'b1;
    mem[12'hF14] = 32'h0000_0007; mapped[12'hF14] = 1'b1;
    csr_rd = 32'h0;
    forever begin
      @(posedge clk);
      csr_rd <= mem[csr_ra];
      if (csr_we) begin
        mem[csr_wa] <= csr_wd;
        we_count++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called right after the accepting edge; walks the four-cycle sequence and completes the response.
  task automatic run_txn(input string tag, input logic exp_we, input logic [11:0] exp_wa,
                         input logic [31:0] exp_wd, input logic [31:0] exp_data,
                         input logic exp_ill);
    int          we_start;
    logic        we_at3;
    logic        early_vld;
    logic        busy_rdy;
    logic [11:0] wa3;
    logic [31:0] wd3;
    we_start  = we_count;
    we_at3    = 1'b0;
    early_vld = 1'b0;
    busy_rdy  = 1'b0;
    wa3       = '0;
    wd3       = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      busy_rdy = busy_rdy | req_ready;
      if (k == 3) begin
        we_at3 = csr_we;
        wa3    = csr_wa;
        wd3    = csr_wd;
      end
      if (k < 4) early_vld = early_vld | rsp_valid;
    end
    chk({tag, ".req_ready_busy"}, 32'(busy_rdy), 32'd0);
    chk({tag, ".early_rsp"}, 32'(early_vld), 32'd0);
    chk({tag, ".we_e3"}, 32'(we_at3), 32'(exp_we));
    if (exp_we) begin
      chk({tag, ".wa"}, 32'(wa3), 32'(exp_wa));
      chk({tag, ".wd"}, wd3, exp_wd);
    end
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_data"}, rsp_data, exp_data);
    chk({tag, ".rsp_illegal"}, 32'(rsp_illegal), 32'(exp_ill));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".we_count"}, 32'(we_count - we_start), 32'(exp_we));
  endtask

  task automatic do_txn(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [4:0] field, input logic [31:0] data,
                        input logic exp_we, input logic [31:0] exp_wd,
                        input logic [31:0] exp_data, input logic exp_ill);
    req_funct3    = f3;
    req_addr      = addr;
    req_rs1_field = field;
    req_rs1_data  = data;
    req_valid     = 1'b1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    run_txn(tag, exp_we, addr, exp_wd, exp_data, exp_ill);
  endtask

  initial begin
    int we0;
    logic busy;
    rst_n = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_addr = '0;
    req_rs1_field = '0; req_rs1_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_data", rsp_data, 32'd0);
    chk("rst.rsp_illegal", 32'(rsp_illegal), 32'd0);
    chk("rst.csr_we", 32'(csr_we), 32'd0);
    chk("rst.csr_wd", csr_wd, 32'd0);
    chk("rst.csr_wa", 32'(csr_wa), 32'd0);
    chk("rst.csr_ra", 32'(csr_ra), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn("rw_mscratch", 3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    do_txn("rs_mstatus",  3'b010, 12'h300, 5'd5, 32'h0000_0008, 1'b1, 32'h0000_1808, 32'h0000_1800, 1'b0);
    do_txn("rsi_zero",    3'b110, 12'h300, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0000_1808, 1'b0);
    do_txn("rc_mie",      3'b011, 12'h304, 5'd7, 32'h0000_0880, 1'b1, 32'h0000_0008, 32'h0000_0888, 1'b0);
    do_txn("rci_3",       3'b111, 12'h305, 5'd3, 32'hFFFF_FFFF, 1'b1, 32'h0000_000C, 32'h0000_000F, 1'b0);
    do_txn("rwi_zero",    3'b101, 12'h304, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0008, 1'b0);
    do_txn("rw_ro",       3'b001, 12'hF14, 5'd1, 32'h0000_0055, 1'b0, 32'h0,         32'h0,         1'b1);
    do_txn("rs_ro_read",  3'b010, 12'hF14, 5'd0, 32'h0000_0055, 1'b0, 32'h0,         32'h0000_0007, 1'b0);
    do_txn("unmapped",    3'b010, 12'h7C0, 5'd1, 32'h0000_0001, 1'b0, 32'h0,         32'h0,         1'b1);
    do_txn("funct3_000",  3'b000, 12'h340, 5'd1, 32'h0000_0001, 1'b0, 32'h0,         32'h0,         1'b1);

    // response backpressure with a second request held valid throughout
    req_funct3 = 3'b010; req_addr = 12'h300; req_rs1_field = 5'd0; req_rs1_data = 32'h0;
    req_valid  = 1'b1;
    @(posedge clk);
    busy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      busy = busy | req_ready;
    end
    chk("bp.rsp_data0", rsp_data, 32'h0000_1808);
    for (int h = 1; h <= 3; h++) begin
      @(negedge clk);
      busy = busy | req_ready;
      chk("bp.rsp_hold", rsp_data, 32'h0000_1808);
      chk("bp.rsp_valid_hold", 32'(rsp_valid), 32'd1);
    end
    chk("bp.req_ready_low", 32'(busy), 32'd0);
    req_addr  = 12'hF14;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    run_txn("bp.second", 1'b0, 12'hF14, 32'h0, 32'h0000_0007, 1'b0);

    // reset asserted while in MODIFY of a write
    req_funct3 = 3'b001; req_addr = 12'h340; req_rs1_field = 5'd1; req_rs1_data = 32'h0BAD_F00D;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    we0   = we_count;
    rst_n = 1'b0;
    #1;
    chk("mrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst.req_ready", 32'(req_ready), 32'd1);
    chk("mrst.csr_we", 32'(csr_we), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("mrst.no_write", 32'(we_count - we0), 32'd0);
    @(negedge clk);
    do_txn("mrst.readback", 3'b010, 12'h340, 5'd0, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
